dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Memory-side responder for the pipeline's data-memory request interface.
//   Services one load/store at a time: valid/ready request, fixed wait-state latency, valid/ready response.
//   Sits between the Mem stage (initiator) and a word-organised SRAM array held inside this block.
//   busy lets the hazard logic stall the pipeline while an access is outstanding.
// PARAMETERS
//   DEPTH_WORDS  1024  number of 32-bit words; power of two, >= 2
//   WAIT_CYCLES  2     cycles spent in ACCESS; legal range 0..15
// PORTS
//   clk        in   1   single clock; all state updates on rising edge
//   rst        in   1   synchronous, active-high reset
//   req_valid  in   1   request present
//   req_ready  out  1   responder can accept a request
//   req_we     in   1   1 = store, 0 = load
//   req_addr   in   32  byte address
//   req_wdata  in   32  store data, lane-aligned
//   req_be     in   4   byte enables; bit i selects wdata[8i+7:8i]
//   rsp_valid  out  1   response present
//   rsp_ready  in   1   initiator accepts response
//   rsp_rdata  out  32  load data (full word); 0 for stores and errors
//   rsp_err    out  1   access faulted (see CONFIGURATION)
//   busy       out  1   high in ACCESS or RESP
// BEHAVIOUR
//   Reset: state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
//   Array contents are not reset. rst has priority over every other event.
//   req_ready = (state==IDLE); it is combinational from state only and never depends on req_valid.
//   FSM:
//     IDLE:   on req_valid&&req_ready, capture we/addr/wdata/be.
//             Load counter with WAIT_CYCLES.
//             Next state is ACCESS if WAIT_CYCLES>0, else COMMIT.
//     ACCESS: counter decrements each cycle; go to COMMIT when counter reaches 1.
//             Total cycles in ACCESS = WAIT_CYCLES.
//     COMMIT: one cycle; performs the array operation.
//             Store: byte-masked write.
//             Load: read the word into rsp_rdata.
//             Registers rsp_err, sets rsp_valid=1, then goes to RESP.
//     RESP:   rsp_valid=1; rsp_rdata and rsp_err are held stable.
//             On rsp_ready, clear rsp_valid next cycle and return to IDLE.
//   Latency: acceptance edge to rsp_valid high = WAIT_CYCLES+2 edges.
//   Throughput: at most one request per WAIT_CYCLES+3 cycles; there is no accept in the same cycle as a response handshake.
//   Word index = addr[log2(DEPTH_WORDS)+1:2].
//   Upper address bits are ignored, so accesses wrap modulo DEPTH_WORDS*4.
//   req_be=4'h0 on a store: no write; a normal response is still returned.
//   A load ignores req_be and returns the full word; lane extraction is the Mem stage's job.
//   Store responses carry rsp_rdata=0.
//   rsp_ready high while rsp_valid is low has no effect.
//   Reset mid-operation: the transaction is abandoned with no response.
//   A store is committed only if the COMMIT edge completed before rst was asserted.
//   req_* inputs are ignored outside IDLE.
// CONFIGURATION
//   DMEM_MISALIGN_ERR_EN defined:
//     A request is misaligned if either:
//       (be==4'hF and addr[1:0]!=0), or
//       (be is 4'b0011 or 4'b1100 and addr[0]==1).
//     A misaligned request runs the full FSM timing.
//     In COMMIT: no array write, rsp_rdata=0, rsp_err=1.
//   DMEM_MISALIGN_ERR_EN undefined:
//     addr[1:0] is ignored entirely, rsp_err is tied to 0, and no alignment logic is built.
// TESTING
//   T1 reset:
//      Hold rst 3 cycles, then release.
//      Required: req_ready=1 on the first cycle after release; rsp_valid=0, busy=0 throughout.
//   T2 store/load, WAIT_CYCLES=2:
//      Store 0xDEADBEEF at 0x10 with be=F, then load 0x10.
//      Required: rsp_valid 4 edges after each accept; load rsp_rdata=0xDEADBEEF.
//   T3 byte-enable merge:
//      Store 0x11223344 at 0x20 with be=F.
//      Store 0xAABBCCDD at 0x20 with be=0101.
//      Load 0x20.
//      Required: rsp_rdata=0x11BB33DD.
//   T4 backpressure and wrap, DEPTH_WORDS=16:
//      Hold rsp_ready=0 for 5 cycles.
//      Required: rsp_valid and rsp_rdata stable, req_ready=0.
//      Then store 0x5A at 0x40 and load 0x00.
//      Required: load returns 0x5A.
//   T5 reset mid-access:
//      Store 0xFFFFFFFF at 0x8 (prior value 0).
//      Assert rst during ACCESS, then load 0x8.
//      Required: rsp_rdata=0; no response was emitted for the aborted store.
//   T6 misalign, macro defined:
//      Load at 0x2 with be=F.
//      Required: rsp_err=1, rsp_rdata=0.
//      Store at 0x1 with be=0011.
//      Required: rsp_err=1; memory unchanged.
//      Macro undefined: same stimulus gives rsp_err=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time through IDLE/ACCESS/COMMIT/RESP with a word SRAM inside.
// Optional macro DMEM_MISALIGN_ERR_EN turns misaligned requests into error responses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshakes: a request transfers on a rising edge with req_valid && req_ready,
  // a response on a rising edge with rsp_valid && rsp_ready; once raised, valid and
  // its payload hold until that transfer, and ready never depends on valid.

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_rdata;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          w_fault;

`ifdef DMEM_MISALIGN_ERR_EN
  logic [1:0] r_lo;
  logic       r_rsp_err;
  logic       w_unused_addr;

  assign w_fault = ((r_be == 4'hF) && (r_lo != 2'd0)) ||
                   (((r_be == 4'b0011) || (r_be == 4'b1100)) && r_lo[0]);
  assign rsp_err = r_rsp_err;
  assign w_unused_addr = ^req_addr[31:AW+2];
`else
  logic w_unused_addr;

  assign w_fault = 1'b0;
  assign rsp_err = 1'b0;
  assign w_unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = (r_state != S_IDLE);
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
`ifdef DMEM_MISALIGN_ERR_EN
      r_lo        <= 2'd0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_idx   <= req_addr[AW+1:2];
            r_wdata <= req_wdata;
            r_be    <= req_be;
`ifdef DMEM_MISALIGN_ERR_EN
            r_lo    <= req_addr[1:0];
`endif
            r_cnt   <= LP_WAIT;
            r_state <= (LP_WAIT != 4'd0) ? S_ACCESS : S_COMMIT;
          end
        end
        S_ACCESS: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= S_COMMIT;
        end
        S_COMMIT: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= (!r_we && !w_fault) ? r_mem[r_idx] : 32'd0;
`ifdef DMEM_MISALIGN_ERR_EN
          r_rsp_err   <= w_fault;
`endif
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A reset arriving on the commit edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_COMMIT) && r_we && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder (16 words, 2 wait states): directed scenarios plus random
// traffic scored against a word-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 16;
  localparam int WAIT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  logic        exp_err_q [$];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic misaligned(input logic [31:0] addr, input logic [3:0] be);
`ifdef DMEM_MISALIGN_ERR_EN
    if (be == 4'hF && (addr % 4) != 0) return 1'b1;
    if ((be == 4'b0011 || be == 4'b1100) && (addr % 2) != 0) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: memory as an array of words, bytes merged by enable.
  task automatic model_apply(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
    int idx;
    idx = int'((addr / 4) % DEPTH);
    if (misaligned(addr, be)) begin
      exp_q.push_back(32'd0);
      exp_err_q.push_back(1'b1);
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
      exp_q.push_back(32'd0);
      exp_err_q.push_back(1'b0);
    end else begin
      exp_q.push_back(model[idx]);
      exp_err_q.push_back(1'b0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_busy", busy, 0);
  endtask

  // One full transaction; inputs change on the falling edge, outputs sampled there too.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold);
    int          lat;
    logic [31:0] e_rd;
    logic        e_err;
    check("req_ready_idle", req_ready, 1);
    model_apply(we, addr, wdata, be);
    rsp_ready = (hold == 0);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 1;
    check("busy_access", busy, 1);
    check("req_ready_access", req_ready, 0);
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    check("latency_edges", lat, WAIT + 2);
    e_rd  = exp_q.pop_front();
    e_err = exp_err_q.pop_front();
    check("rsp_rdata", rsp_rdata, e_rd);
    check("rsp_err", rsp_err, e_err);
    check("busy_resp", busy, 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, e_rd);
      check("bp_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_busy", busy, 0);
    check("done_req_ready", req_ready, 1);
  endtask

  // Store interrupted by reset some edges after acceptance; must leave no trace.
  task automatic aborted_store(input logic [31:0] addr, input logic [31:0] wdata, input int extra);
    int seen;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = wdata; req_be = 4'hF;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    repeat (extra) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("abort_req_ready", req_ready, 1);
    check("abort_busy", busy, 0);
    seen = 0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("abort_no_response", seen, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_be = 4'd0; rsp_ready = 1'b0;

    do_reset();

    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(i * 4), 32'd0, 4'hF, 0);

    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    xact(1'b0, 32'h10, 32'd0, 4'hF, 0);

    xact(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    xact(1'b0, 32'h20, 32'd0, 4'hF, 0);

    xact(1'b0, 32'h20, 32'd0, 4'hF, 5);
    xact(1'b1, 32'h40, 32'h0000005A, 4'hF, 0);
    xact(1'b0, 32'h00, 32'd0, 4'hF, 0);

    xact(1'b1, 32'h44, 32'h12345678, 4'h0, 0);
    xact(1'b0, 32'h04, 32'd0, 4'h0, 0);

    aborted_store(32'h8, 32'hFFFFFFFF, 0);
    xact(1'b0, 32'h8, 32'd0, 4'hF, 0);
    aborted_store(32'h8, 32'hFFFFFFFF, 2);
    xact(1'b0, 32'h8, 32'd0, 4'hF, 0);

    xact(1'b0, 32'h2, 32'd0, 4'hF, 0);
    xact(1'b1, 32'h1, 32'hCAFEF00D, 4'b0011, 0);
    xact(1'b0, 32'h0, 32'd0, 4'hF, 0);

    for (int n = 0; n < 60; n++) begin
      xact(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
           4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
